vreg_xfer_ctrl: RTL and testbench

//   Initiator side of the vector-register serial port. Accepts whole-vector commands
//   (parallel 256-bit words) and sequences the 16-cycle serial bursts that write into
//   or read out of the eight 16x16 vector registers (WR_s/RD_s/DataIn_s/DataOut_s/Addr).

---
 rtl/vreg_xfer_ctrl_pkg.sv | 32 +++
 rtl/vreg_burst_cnt.sv | 26 ++
 rtl/vreg_xfer_ctrl.sv | 157 +++++++++++++++
 tb/tb_vreg_xfer_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vreg_xfer_ctrl_pkg.sv
// Shared definitions for the vector-register serial transfer controller:
// geometry, opcodes, FSM state encoding and an element-select helper.
package vreg_xfer_ctrl_pkg;

    localparam int VREG_ELEMS   = 16;
    localparam int VREG_WIDTH   = 16;
    localparam int VREG_ADDR_W  = 3;
    localparam int VREG_GAP_CYC = 2;
    localparam int VREG_DATA_W  = VREG_ELEMS * VREG_WIDTH;
    localparam int VREG_CNT_W   = $clog2(VREG_ELEMS);
    localparam int VREG_GAP_W   = $clog2(VREG_GAP_CYC + 1);

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_BURST = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    function automatic logic [VREG_WIDTH-1:0] elem_sel(
        input logic [VREG_DATA_W-1:0] vec,
        input logic [VREG_CNT_W-1:0]  idx
    );
        return vec[idx*VREG_WIDTH +: VREG_WIDTH];
    endfunction

endpackage

// File: rtl/vreg_burst_cnt.sv
// Element counter for one serial burst: cleared by start, advanced by en,
// last flags the final element of the vector.
module vreg_burst_cnt
    import vreg_xfer_ctrl_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  start,
    input  logic                  en,
    output logic [VREG_CNT_W-1:0] cnt,
    output logic                  last
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == VREG_CNT_W'(VREG_ELEMS - 1));

endmodule

// File: rtl/vreg_xfer_ctrl.sv
// Initiator for the vector-register serial port: turns whole-vector commands
// into 16-cycle WR_s/RD_s bursts and returns read vectors in parallel.
module vreg_xfer_ctrl
    import vreg_xfer_ctrl_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Cmd_valid,
    output logic                   Cmd_ready,
    input  logic                   Cmd_op,
    input  logic [VREG_ADDR_W-1:0] Cmd_addr,
    input  logic [VREG_ADDR_W-1:0] Cmd_addr2,
    input  logic [VREG_DATA_W-1:0] Ld_data,
    output logic                   Rsp_valid,
    input  logic                   Rsp_ready,
    output logic                   Rsp_op,
    output logic [VREG_DATA_W-1:0] St_data,
    output logic [VREG_DATA_W-1:0] St_data2,
    output logic [VREG_ADDR_W-1:0] Addr,
    output logic [VREG_ADDR_W-1:0] Addr2,
    output logic                   WR_s,
    output logic                   RD_s,
    output logic [VREG_WIDTH-1:0]  DataIn_s,
    input  logic [VREG_WIDTH-1:0]  DataOut_s,
    input  logic [VREG_WIDTH-1:0]  DataOut2_s,
    output state_t                 Dbg_state
);

    // Cmd and Rsp are valid/ready handshakes: a transfer happens on a rising
    // edge where valid and ready are both high; the sender holds valid and its
    // payload stable until then, and ready never depends on valid.

    state_t                  state;
    state_t                  state_nxt;
    logic                    op_q;
    logic [VREG_DATA_W-1:0]  buf_q;
    logic [VREG_GAP_W-1:0]   gap_cnt;
    logic                    cap_en;
    logic                    accept;
    logic [VREG_CNT_W-1:0]   elem;
    logic                    elem_last;
    logic [VREG_CNT_W-1:0]   cap;
    logic                    cap_last;

    assign accept    = Cmd_valid && Cmd_ready;
    assign Rsp_op    = op_q;
    assign Dbg_state = state;

    vreg_burst_cnt u_issue_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (state == ST_SETUP),
        .en    (state == ST_BURST),
        .cnt   (elem),
        .last  (elem_last)
    );

    // Read data lags the strobe by one cycle, so capture runs one element behind issue.
    vreg_burst_cnt u_cap_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (state == ST_SETUP),
        .en    (cap_en),
        .cnt   (cap),
        .last  (cap_last)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_q     <= OP_WR;
            buf_q    <= '0;
            Addr     <= '0;
            Addr2    <= '0;
            cap_en   <= 1'b0;
            gap_cnt  <= '0;
            St_data  <= '0;
            St_data2 <= '0;
        end else begin
            cap_en <= RD_s;
            // Addresses load at accept so they are stable through all of SETUP.
            if (accept) begin
                op_q  <= Cmd_op;
                buf_q <= Ld_data;
                Addr  <= Cmd_addr;
                Addr2 <= Cmd_addr2;
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            if (cap_en) begin
                St_data[cap*VREG_WIDTH +: VREG_WIDTH]  <= DataOut_s;
                St_data2[cap*VREG_WIDTH +: VREG_WIDTH] <= DataOut2_s;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        Cmd_ready = 1'b0;
        Rsp_valid = 1'b0;
        WR_s      = 1'b0;
        RD_s      = 1'b0;
        DataIn_s  = '0;
        case (state)
            ST_IDLE: begin
                Cmd_ready = 1'b1;
                if (Cmd_valid) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_BURST;
            end
            ST_BURST: begin
                if (op_q == OP_WR) begin
                    WR_s     = 1'b1;
                    DataIn_s = elem_sel(buf_q, elem);
                end else begin
                    RD_s = 1'b1;
                end
                if (elem_last) begin
                    state_nxt = (op_q == OP_RD) ? ST_DRAIN : ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (cap_last) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                Rsp_valid = 1'b1;
                if (Rsp_ready) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == VREG_GAP_W'(VREG_GAP_CYC - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vreg_xfer_ctrl.sv
// Bench for vreg_xfer_ctrl: behavioural register file on the serial side,
// shadow register contents as reference, randomized command traffic.
module tb_vreg_xfer_ctrl;
    import vreg_xfer_ctrl_pkg::*;

    localparam int DW = VREG_DATA_W;

    logic                   Clk = 1'b0;
    logic                   Rst_n = 1'b0;
    logic                   Cmd_valid = 1'b0;
    logic                   Cmd_ready;
    logic                   Cmd_op = 1'b0;
    logic [VREG_ADDR_W-1:0] Cmd_addr = '0;
    logic [VREG_ADDR_W-1:0] Cmd_addr2 = '0;
    logic [DW-1:0]          Ld_data = '0;
    logic                   Rsp_valid;
    logic                   Rsp_ready = 1'b1;
    logic                   Rsp_op;
    logic [DW-1:0]          St_data;
    logic [DW-1:0]          St_data2;
    logic [VREG_ADDR_W-1:0] Addr;
    logic [VREG_ADDR_W-1:0] Addr2;
    logic                   WR_s;
    logic                   RD_s;
    logic [VREG_WIDTH-1:0]  DataIn_s;
    logic [VREG_WIDTH-1:0]  DataOut_s = '0;
    logic [VREG_WIDTH-1:0]  DataOut2_s = '0;
    state_t                 dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [VREG_WIDTH-1:0] mem [0:7][0:15];
    int                    wr_idx = 0;
    int                    rd_idx = 0;
    logic [DW-1:0]         shadow [0:7];
    logic [DW-1:0]         exp_st1 = '0;
    logic [DW-1:0]         exp_st2 = '0;
    int                    idle_run = 0;
    bit                    seen_burst = 1'b0;

    vreg_xfer_ctrl dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Cmd_valid  (Cmd_valid),
        .Cmd_ready  (Cmd_ready),
        .Cmd_op     (Cmd_op),
        .Cmd_addr   (Cmd_addr),
        .Cmd_addr2  (Cmd_addr2),
        .Ld_data    (Ld_data),
        .Rsp_valid  (Rsp_valid),
        .Rsp_ready  (Rsp_ready),
        .Rsp_op     (Rsp_op),
        .St_data    (St_data),
        .St_data2   (St_data2),
        .Addr       (Addr),
        .Addr2      (Addr2),
        .WR_s       (WR_s),
        .RD_s       (RD_s),
        .DataIn_s   (DataIn_s),
        .DataOut_s  (DataOut_s),
        .DataOut2_s (DataOut2_s),
        .Dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- register file model ----------------
    always @(posedge Clk) begin
        if (WR_s && wr_idx < VREG_ELEMS) mem[Addr][wr_idx] <= DataIn_s;
        wr_idx <= WR_s ? wr_idx + 1 : 0;
        if (RD_s && rd_idx < VREG_ELEMS) begin
            DataOut_s  <= mem[Addr][rd_idx];
            DataOut2_s <= mem[Addr2][rd_idx];
        end
        rd_idx <= RD_s ? rd_idx + 1 : 0;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Idle spacing between bursts and strobe exclusivity.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            seen_burst <= 1'b0;
            idle_run   <= 0;
        end else if (WR_s || RD_s) begin
            check("strobe_excl", {255'd0, WR_s && RD_s}, '0);
            if (seen_burst && idle_run > 0) check("gap_len", {255'd0, idle_run >= VREG_GAP_CYC + 2}, 1);
            seen_burst <= 1'b1;
            idle_run   <= 0;
        end else begin
            idle_run <= idle_run + 1;
        end
    end

    function automatic logic [DW-1:0] make_vec(input logic [15:0] base);
        logic [DW-1:0] v;
        for (int k = 0; k < VREG_ELEMS; k++) v[k*16 +: 16] = base + 16'(k);
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int k = 0; k < VREG_ELEMS; k++) v[k*16 +: 16] = 16'($urandom);
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic do_cmd(input logic op, input logic [2:0] a, input logic [2:0] a2,
                          input logic [DW-1:0] d, input int hold);
        int n;
        int n_str;
        int first_str;
        int t_acc;
        Cmd_valid = 1'b1;
        Cmd_op    = op;
        Cmd_addr  = a;
        Cmd_addr2 = a2;
        Ld_data   = d;
        Rsp_ready = (hold == 0);
        n = 0;
        while (!Cmd_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("accept_wait", {255'd0, n < 200}, 1);
        t_acc = cyc + 1;
        @(negedge Clk);
        Cmd_valid = 1'b0;
        n_str = 0;
        first_str = -1;
        n = 0;
        while (!Rsp_valid && n < 60) begin
            if (op == OP_WR ? WR_s : RD_s) begin
                n_str++;
                if (first_str < 0) first_str = cyc - t_acc;
            end
            @(negedge Clk);
            n++;
        end
        check("rsp_wait", {255'd0, n < 60}, 1);
        check("rsp_latency", DW'(cyc - t_acc), (op == OP_RD) ? 18 : 17);
        check("strobe_cycles", DW'(n_str), 16);
        check("strobe_start", DW'(first_str), 1);
        check("rsp_op", {255'd0, Rsp_op}, {255'd0, op});
        if (op == OP_WR) begin
            shadow[a] = d;
        end else begin
            exp_st1 = shadow[a];
            exp_st2 = shadow[a2];
        end
        check("st_data", St_data, exp_st1);
        check("st_data2", St_data2, exp_st2);
        for (int i = 0; i < hold; i++) begin
            Cmd_valid = 1'b1;
            Cmd_op    = ~op;
            Cmd_addr  = 3'($urandom_range(0, 7));
            Ld_data   = rand_vec();
            @(negedge Clk);
            check("stall_valid", {255'd0, Rsp_valid}, 1);
            check("stall_data", St_data, exp_st1);
            check("stall_ready", {255'd0, Cmd_ready}, 0);
            check("stall_strobe", {255'd0, WR_s | RD_s}, 0);
        end
        Cmd_valid = 1'b0;
        Rsp_ready = 1'b1;
        @(negedge Clk);
        check("rsp_drop", {255'd0, Rsp_valid}, 0);
        check("post_data2", St_data2, exp_st2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] b2b_v [0:2];
        logic [2:0]    b2b_a [0:2];
        int n;
        int cnt;
        for (int r = 0; r < 8; r++) begin
            shadow[r] = '0;
            for (int k = 0; k < VREG_ELEMS; k++) mem[r][k] = '0;
        end

        repeat (3) @(negedge Clk);
        check("rst_cmd_ready_in_reset", {255'd0, Cmd_ready}, 1);
        check("rst_wr_in_reset", {255'd0, WR_s}, 0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_cmd_ready", {255'd0, Cmd_ready}, 1);
        check("rst_rsp_valid", {255'd0, Rsp_valid}, 0);
        check("rst_strobes", {254'd0, WR_s, RD_s}, 0);
        check("rst_addr", {250'd0, Addr, Addr2}, 0);
        check("rst_datain", {240'd0, DataIn_s}, 0);
        check("rst_st_data", St_data, 0);
        check("rst_st_data2", St_data2, 0);
        check("rst_rsp_op", {255'd0, Rsp_op}, 0);

        // Write then read back a ramp.
        do_cmd(OP_WR, 3'd0, 3'd0, make_vec(16'hA000), 0);
        do_cmd(OP_RD, 3'd0, 3'd0, '0, 0);

        // Two registers on the two read ports.
        do_cmd(OP_WR, 3'd2, 3'd0, make_vec(16'h2000), 0);
        do_cmd(OP_WR, 3'd5, 3'd0, make_vec(16'h5000), 0);
        do_cmd(OP_RD, 3'd2, 3'd5, '0, 0);

        // Response back-pressure with busy-time command requests.
        do_cmd(OP_WR, 3'd1, 3'd0, rand_vec(), 0);
        do_cmd(OP_RD, 3'd1, 3'd2, '0, 5);

        // Same register on both ports, top element all ones.
        v = rand_vec();
        v[15*16 +: 16] = 16'hFFFF;
        do_cmd(OP_WR, 3'd4, 3'd0, v, 0);
        do_cmd(OP_RD, 3'd4, 3'd4, '0, 0);

        for (int i = 0; i < 14; i++) begin
            do_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   rand_vec(), int'($urandom_range(0, 3)));
        end

        // Three writes with Cmd_valid held high throughout.
        b2b_a[0] = 3'd1;
        b2b_a[1] = 3'd6;
        b2b_a[2] = 3'd7;
        Rsp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            b2b_v[j]  = rand_vec();
            Cmd_valid = 1'b1;
            Cmd_op    = OP_WR;
            Cmd_addr  = b2b_a[j];
            Ld_data   = b2b_v[j];
            n = 0;
            while (!Cmd_ready && n < 200) begin
                @(negedge Clk);
                n++;
            end
            check("b2b_accept", {255'd0, n < 200}, 1);
            check("b2b_idle_quiet", {253'd0, Rsp_valid, WR_s, RD_s}, 0);
            shadow[b2b_a[j]] = b2b_v[j];
            @(negedge Clk);
        end
        Cmd_valid = 1'b0;
        n = 0;
        while (!Cmd_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("b2b_done", {255'd0, n < 200}, 1);
        do_cmd(OP_RD, 3'd1, 3'd6, '0, 0);
        do_cmd(OP_RD, 3'd7, 3'd7, '0, 0);

        // Reset in the middle of a write burst.
        v = rand_vec();
        Cmd_valid = 1'b1;
        Cmd_op    = OP_WR;
        Cmd_addr  = 3'd3;
        Ld_data   = v;
        n = 0;
        while (!Cmd_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        Cmd_valid = 1'b0;
        cnt = 0;
        n = 0;
        while (n < 40) begin
            if (WR_s) cnt++;
            if (cnt == 8) break;
            @(negedge Clk);
            n++;
        end
        check("rst_reach_elem7", DW'(cnt), 8);
        check("rst_elem7_data", {240'd0, DataIn_s}, {240'd0, v[7*16 +: 16]});
        #1 Rst_n = 1'b0;
        #1;
        check("rst_async_wr", {255'd0, WR_s}, 0);
        check("rst_async_rsp", {255'd0, Rsp_valid}, 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        exp_st1 = '0;
        exp_st2 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (i == 0) check("rst_mid_ready", {255'd0, Cmd_ready}, 1);
            if (Rsp_valid) check("rst_mid_no_rsp", {255'd0, Rsp_valid}, 0);
        end
        check("rst_mid_st_data", St_data, 0);
        do_cmd(OP_WR, 3'd3, 3'd0, rand_vec(), 0);
        do_cmd(OP_RD, 3'd3, 3'd2, '0, 0);
        do_cmd(OP_RD, 3'd0, 3'd5, '0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
